// File: rtl/mul32_seq.sv
// Sequential 32x32 -> 64 multiplier built around an external combinational 16x16 multiplier.
// Optional signed mode is enabled by defining MUL32_SEQ_SIGNED_EN (adds the is_signed port).
module mul32_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
`ifdef MUL32_SEQ_SIGNED_EN
  input  logic        is_signed,
`endif
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic        mul_en,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [31:0] mul_p
);

  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, MUL3, DONE} state_t;

  state_t      state_q;
  logic [31:0] a_q, b_q;
  logic [63:0] acc_q, result_q;
  logic        busy_q, done_q, mul_en_q;
  logic [15:0] mul_a_q, mul_b_q;

  logic [31:0] a_d, b_d;
  logic [63:0] addend_d, sum_d, final_d;
`ifdef MUL32_SEQ_SIGNED_EN
  logic        neg_q, neg_d;
`endif

  // Signed mode multiplies magnitudes; 0x80000000 stays 0x80000000, i.e. 2^31 unsigned.
  always_comb begin
    a_d = opa;
    b_d = opb;
`ifdef MUL32_SEQ_SIGNED_EN
    neg_d = 1'b0;
    if (is_signed) begin
      a_d   = opa[31] ? (~opa + 32'd1) : opa;
      b_d   = opb[31] ? (~opb + 32'd1) : opb;
      neg_d = opa[31] ^ opb[31];
    end
`endif
  end

  always_comb begin
    case (state_q)
      MUL1, MUL2: addend_d = {16'b0, mul_p, 16'b0};
      MUL3:       addend_d = {mul_p, 32'b0};
      default:    addend_d = {32'b0, mul_p};
    endcase
    sum_d   = acc_q + addend_d;
    final_d = sum_d;
`ifdef MUL32_SEQ_SIGNED_EN
    if (neg_q) final_d = ~sum_d + 64'd1;
`endif
  end

  // Multiplier operands are registered one state ahead so they line up with the state using mul_p.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mul_en_q <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
`ifdef MUL32_SEQ_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= '0;
            busy_q   <= 1'b1;
            mul_en_q <= 1'b1;
            mul_a_q  <= a_d[15:0];
            mul_b_q  <= b_d[15:0];
`ifdef MUL32_SEQ_SIGNED_EN
            neg_q    <= neg_d;
`endif
            state_q  <= MUL0;
          end
        end
        MUL0: begin
          acc_q   <= {32'b0, mul_p};
          mul_b_q <= b_q[31:16];
          state_q <= MUL1;
        end
        MUL1: begin
          acc_q   <= sum_d;
          mul_a_q <= a_q[31:16];
          mul_b_q <= b_q[15:0];
          state_q <= MUL2;
        end
        MUL2: begin
          acc_q   <= sum_d;
          mul_b_q <= b_q[31:16];
          state_q <= MUL3;
        end
        MUL3: begin
          acc_q    <= sum_d;
          result_q <= final_d;
          done_q   <= 1'b1;
          mul_en_q <= 1'b0;
          mul_a_q  <= '0;
          mul_b_q  <= '0;
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign mul_en = mul_en_q;
  assign mul_a  = mul_a_q;
  assign mul_b  = mul_b_q;

endmodule

// File: tb/tb_mul32_seq.sv
// Scoreboard bench for mul32_seq: stimulus pushes expected products, a monitor pops them on done.
// Signed-mode cases are compiled in only when MUL32_SEQ_SIGNED_EN is defined.
module tb_mul32_seq;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] opa, opb;
  logic        busy, done, mul_en;
  logic [63:0] result;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_p;
`ifdef MUL32_SEQ_SIGNED_EN
  logic        is_signed;
`endif

  logic [63:0] expq[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [63:0] prevResult = '0;

  always #5 clk = ~clk;

  // Stand-in for the external 16x16 combinational multiplier.
  assign mul_p = {16'b0, mul_a} * {16'b0, mul_b};

  mul32_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opa(opa), .opb(opb),
`ifdef MUL32_SEQ_SIGNED_EN
    .is_signed(is_signed),
`endif
    .busy(busy), .done(done), .result(result), .mul_en(mul_en),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb;
    longint unsigned ua, ub;
    if (sgn) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      return 64'(sa * sb);
    end
    ua = 64'(a);
    ub = 64'(b);
    return ua * ub;
  endfunction

  // Issue one start in IDLE; returns just after the accepting edge (DUT now in MUL0).
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                               input logic [63:0] exp);
    @(posedge clk); #1;
    for (int i = 0; i < 20 && busy; i++) begin
      @(posedge clk); #1;
    end
    opa   = a;
    opb   = b;
`ifdef MUL32_SEQ_SIGNED_EN
    is_signed = sgn;
`endif
    start = 1'b1;
    expq.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) checkOutput({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Monitor: pops the scoreboard on every done and watches output invariants each cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevResult = '0;
      end else begin
        if (!mul_en) checkOutput("mul_ab_idle_zero", {32'b0, mul_a, mul_b}, 64'd0);
        if (done) begin
          if (expq.size() == 0) checkOutput("unexpected_done", 64'(done), 64'd0);
          else checkOutput("result", result, expq.pop_front());
        end else begin
          checkOutput("result_hold", result, prevResult);
        end
        prevResult = result;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    bit          rs;
    int          gap;
    bit          expBusy[6] = '{1, 1, 1, 1, 1, 0};
    bit          expEn[6]   = '{1, 1, 1, 1, 0, 0};
    bit          expDone[6] = '{0, 0, 0, 0, 1, 0};
    logic [15:0] expA[6]    = '{16'd3, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0};
    logic [15:0] expB[6]    = '{16'd5, 16'd0, 16'd5, 16'd0, 16'd0, 16'd0};

    rst_n = 1'b0; start = 1'b0; opa = '0; opb = '0;
`ifdef MUL32_SEQ_SIGNED_EN
    is_signed = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_mul_en", 64'(mul_en), 64'd0);
    checkOutput("rst_result", result, 64'd0);
    rst_n = 1'b1;

    // 3 x 5 with a cycle-by-cycle view of the handshake and multiplier operands.
    applyStimulus(32'd3, 32'd5, 0, 64'h000000000000000F);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t1_busy_c%0d", k + 1), 64'(busy), 64'(expBusy[k]));
      checkOutput($sformatf("t1_mul_en_c%0d", k + 1), 64'(mul_en), 64'(expEn[k]));
      checkOutput($sformatf("t1_done_c%0d", k + 1), 64'(done), 64'(expDone[k]));
      checkOutput($sformatf("t1_mul_a_c%0d", k + 1), 64'(mul_a), 64'(expA[k]));
      checkOutput($sformatf("t1_mul_b_c%0d", k + 1), 64'(mul_b), 64'(expB[k]));
    end

    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 64'hFFFFFFFE00000001);
    waitDone("t2");

    // Start pulse and operand changes while in MUL1 must be ignored.
    applyStimulus(32'h12345678, 32'h9ABCDEF0, 0, 64'h0B00EA4E242D2080);
    @(posedge clk); #1;
    start = 1'b1; opa = $urandom; opb = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone("t3");
    repeat (8) @(negedge clk);

    // Start held high through DONE: second operation begins in the next IDLE cycle.
    @(posedge clk); #1;
    opa = 32'd1000; opb = 32'd77; start = 1'b1;
    expq.push_back(64'd77000);
    expq.push_back(64'd77000);
    waitDone("t4a");
    gap = 0;
    for (int i = 1; i <= 20 && gap == 0; i++) begin
      @(negedge clk);
      if (done) gap = i;
    end
    checkOutput("t4_back_to_back_gap", 64'(gap), 64'd6);
    @(posedge clk); #1;
    start = 1'b0;

    // Reset in MUL2 aborts the operation and clears every output.
    applyStimulus(32'd9, 32'd9, 0, 64'd81);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    expq.delete();
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_mul_en", 64'(mul_en), 64'd0);
    checkOutput("abort_mul_ab", {32'b0, mul_a, mul_b}, 64'd0);
    checkOutput("abort_result", result, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(32'd2, 32'd7, 0, 64'h000000000000000E);
    waitDone("t5");

`ifdef MUL32_SEQ_SIGNED_EN
    applyStimulus(32'hFFFFFFFF, 32'd2, 1, 64'hFFFFFFFFFFFFFFFE);
    waitDone("s1");
    applyStimulus(32'h80000000, 32'h80000000, 1, 64'h4000000000000000);
    waitDone("s2");
`endif

    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 0;
`ifdef MUL32_SEQ_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`endif
      if (n % 6 == 0) ra = {ra[31], 31'b0};
      applyStimulus(ra, rb, rs, refProduct(ra, rb, rs));
      waitDone($sformatf("rand%0d", n));
    end

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(expq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
